// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared constants for the two-requester memory port arbiter.
//               These are the FSM state codes and the mux select values
//               (0 = requester A, 1 = requester B).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_A = 2'd1;
    localparam logic [1:0] ST_BUSY_B = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux2to1_32bit.sv
`default_nettype none
// ============================================================================
// Module      : mux2to1_32bit
// Description : 2:1 data multiplexer. Selecting SEL_A passes i_d0 and
//               selecting SEL_B passes i_d1.
// Ports       : i_sel - select
//               i_d0  - requester A data
//               i_d1  - requester B data
//               o_y   - selected data
// Revision    : 1.0 - initial release
// ============================================================================
module mux2to1_32bit
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = (i_sel == SEL_B) ? i_d1 : i_d0;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter that shares one memory port between
//               requester A (instruction fetch) and requester B (load/store).
//               It uses a valid/ready handshake toward memory and aborts a
//               transaction when memory does not respond within TIMEOUT
//               busy cycles.
// Ports       : clk, rst                  - clock, sync active-high reset
//               req/addr/wdata/we _a, _b  - requester inputs
//               mem_valid/addr/wdata/we   - memory request side
//               mem_ready, mem_rdata      - memory response side
//               sel_o                     - mux select (0 = A, 1 = B)
//               done_a, done_b            - completion pulses
//               rdata_o                   - read data, valid with done_x
//               err_o                     - timeout abort flag, with done_x
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [DATA_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              we_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic              we_b,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sel_o,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    // The last BUSY cycle before an abort is the one where the counter
    // holds TIMEOUT-1. The counter starts from zero on the first BUSY cycle.
    localparam logic [CNT_W-1:0] c_CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             w_other_req;

    // The request from the requester that is not being served right now.
    assign w_other_req = (sel_o == SEL_A) ? req_b : req_a;

    assign mem_we = mem_valid & ((sel_o == SEL_B) ? we_b : we_a);

    mux2to1_32bit #(.WIDTH(DATA_W)) u_addr_mux (
        .i_sel (sel_o),
        .i_d0  (addr_a),
        .i_d1  (addr_b),
        .o_y   (mem_addr)
    );

    mux2to1_32bit #(.WIDTH(DATA_W)) u_wdata_mux (
        .i_sel (sel_o),
        .i_d0  (wdata_a),
        .i_d1  (wdata_b),
        .o_y   (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_grant <= SEL_B;
            sel_o        <= SEL_A;
            mem_valid    <= 1'b0;
            done_a       <= 1'b0;
            done_b       <= 1'b0;
            err_o        <= 1'b0;
            rdata_o      <= '0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            err_o  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    // When both requesters are active, A wins unless A was served last.
                    if (req_a && (!req_b || (r_last_grant == SEL_B))) begin
                        r_state   <= ST_BUSY_A;
                        sel_o     <= SEL_A;
                        mem_valid <= 1'b1;
                    end else if (req_b) begin
                        r_state   <= ST_BUSY_B;
                        sel_o     <= SEL_B;
                        mem_valid <= 1'b1;
                    end
                end
                ST_BUSY_A, ST_BUSY_B: begin
                    if (mem_ready) begin
                        rdata_o      <= mem_rdata;
                        done_a       <= (sel_o == SEL_A);
                        done_b       <= (sel_o == SEL_B);
                        r_last_grant <= sel_o;
                        r_cnt        <= '0;
                        // Hand the port straight to a waiting requester. The
                        // requester just served always returns through IDLE,
                        // which gives it time to drop its request after done.
                        if (w_other_req) begin
                            r_state <= (sel_o == SEL_A) ? ST_BUSY_B : ST_BUSY_A;
                            sel_o   <= ~sel_o;
                        end else begin
                            r_state   <= ST_IDLE;
                            mem_valid <= 1'b0;
                        end
                    end else if (r_cnt == c_CNT_LIMIT) begin
                        rdata_o      <= '0;
                        done_a       <= (sel_o == SEL_A);
                        done_b       <= (sel_o == SEL_B);
                        err_o        <= 1'b1;
                        r_last_grant <= sel_o;
                        r_cnt        <= '0;
                        r_state      <= ST_IDLE;
                        mem_valid    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Testbench for mem_port_arbiter. It uses random requesters, a
//               memory responder with random latency, and a transaction-level
//               reference model that feeds a completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [DATA_W-1:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
    logic              mem_ready = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_valid, mem_we, sel_o, done_a, done_b, err_o;
    logic [DATA_W-1:0] mem_addr, mem_wdata, rdata_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a),
        .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .sel_o(sel_o), .done_a(done_a), .done_b(done_b), .rdata_o(rdata_o),
        .err_o(err_o)
    );

    typedef struct {
        logic              who;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model state. It works at transaction level: who holds the
    // port, for how long, and what result each transaction should produce.
    bit                active = 1'b0;
    bit                cur = 1'b0;
    int                age = 0;
    int                lat = 0;
    bit                last = 1'b1;          // after reset, a tie goes to A
    logic [1:0]        mask = 2'b11;         // requesters eligible at the last edge
    bit                rst_prev = 1'b1;
    bit                prev_ra = 1'b0, prev_rb = 1'b0;
    bit                ga, gb;
    int                force_lat = 0;
    bit                use_rdata = 1'b0;
    logic [DATA_W-1:0] fixed_rdata = '0;
    bit                req_en = 1'b0;
    exp_t              m_e, mon_e;

    // Memory responder plus model, evaluated at mid-cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_prev) begin
                chk("reset mem_valid", mem_valid, 0);
                chk("reset sel_o", sel_o, 0);
                chk("reset mem_we", mem_we, 0);
                chk("reset done_a", done_a, 0);
                chk("reset done_b", done_b, 0);
                chk("reset err_o", err_o, 0);
                chk("reset rdata_o", rdata_o, 0);
                active    = 1'b0;
                last      = 1'b1;
                mask      = 2'b11;
                mem_ready = 1'b0;
            end else begin
                ga = prev_ra & mask[0];
                gb = prev_rb & mask[1];
                if (!active && (ga || gb)) begin
                    cur    = (ga && gb) ? ~last : gb;
                    active = 1'b1;
                    age    = 0;
                    lat    = (force_lat > 0) ? force_lat : int'($urandom_range(1, 20));
                end
                if (active) begin
                    age++;
                    chk("busy mem_valid", mem_valid, 1);
                    chk("busy sel_o", sel_o, cur);
                    chk("busy mem_addr", mem_addr, cur ? addr_b : addr_a);
                    chk("busy mem_wdata", mem_wdata, cur ? wdata_b : wdata_a);
                    chk("busy mem_we", mem_we, cur ? we_b : we_a);
                    mem_rdata = use_rdata ? fixed_rdata : $urandom;
                    if (rst) begin
                        mem_ready = 1'b0;
                        active    = 1'b0;
                    end else if (age == lat) begin
                        mem_ready = 1'b1;
                        m_e.who = cur; m_e.rdata = mem_rdata; m_e.err = 1'b0; m_e.due = cyc + 1;
                        sb.push_back(m_e);
                        last   = cur;
                        active = 1'b0;
                        mask   = cur ? 2'b01 : 2'b10;   // only the other side may follow at once
                    end else if (age == TIMEOUT) begin
                        mem_ready = 1'b0;
                        m_e.who = cur; m_e.rdata = '0; m_e.err = 1'b1; m_e.due = cyc + 1;
                        sb.push_back(m_e);
                        last   = cur;
                        active = 1'b0;
                        mask   = 2'b00;                  // abort always passes through IDLE
                    end else begin
                        mem_ready = 1'b0;
                    end
                end else begin
                    chk("idle mem_valid", mem_valid, 0);
                    chk("idle mem_we", mem_we, 0);
                    mask      = 2'b11;
                    mem_ready = 1'($urandom_range(0, 1));   // ignored while idle
                    mem_rdata = $urandom;
                end
            end
        end
        rst_prev = rst;
        prev_ra  = req_a;
        prev_rb  = req_b;
    end

    // Scoreboard monitor: each done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (done_a && done_b) fail_now("done_a and done_b coincident");
            if (done_a || done_b) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    fail_now("unexpected done pulse");
                end else begin
                    mon_e = sb.pop_front();
                    chk("done requester", {31'd0, done_b}, {31'd0, mon_e.who});
                    chk("done rdata_o", rdata_o, mon_e.rdata);
                    chk("done err_o", {31'd0, err_o}, {31'd0, mon_e.err});
                end
            end else begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    fail_now("missing done pulse");
                    void'(sb.pop_front());
                end
                if (err_o) fail_now("err_o without done");
            end
        end
    end

    // Requesters: hold until done, drop on done, re-request at random.
    initial forever begin
        @(posedge clk);
        #1;
        if (done_a) req_a = 1'b0;
        if (done_b) req_b = 1'b0;
        if (req_en && !rst) begin
            if (!req_a && $urandom_range(0, 2) == 0) begin
                req_a = 1'b1; addr_a = $urandom; wdata_a = $urandom; we_a = 1'($urandom_range(0, 1));
            end
            if (!req_b && $urandom_range(0, 2) == 0) begin
                req_b = 1'b1; addr_b = $urandom; wdata_b = $urandom; we_b = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic wait_quiet(input int maxc);
        int n = 0;
        while ((req_a || req_b || active || sb.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) fail_now("timeout waiting for idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic with random memory latency, including timeouts.
        req_en = 1'b1;
        repeat (3000) @(posedge clk);
        #1 req_en = 1'b0;
        wait_quiet(200);

        // Single read from A answered on the first BUSY cycle.
        force_lat = 1; use_rdata = 1'b1; fixed_rdata = 32'h1234_5678;
        addr_a = 32'h0000_0040; wdata_a = '0; we_a = 1'b0; req_a = 1'b1;
        wait_quiet(50);
        use_rdata = 1'b0;

        // Write from B.
        force_lat = 3;
        addr_b = 32'h0000_0100; wdata_b = 32'hDEAD_BEEF; we_b = 1'b1; req_b = 1'b1;
        wait_quiet(50);

        // Ready on exactly the last BUSY cycle before the abort point.
        force_lat = TIMEOUT;
        addr_a = 32'h0000_0200; we_a = 1'b0; req_a = 1'b1;
        wait_quiet(60);

        // No ready at all, so the transaction aborts.
        force_lat = TIMEOUT + 10;
        addr_a = 32'h0000_0300; req_a = 1'b1;
        wait_quiet(60);

        // Simultaneous requests with immediate ready, served back-to-back.
        force_lat = 1;
        addr_a = 32'h0000_0400; addr_b = 32'h0000_0500; we_a = 1'b0; we_b = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        wait_quiet(60);

        // Reset during BUSY_B, then a tie must go to A.
        force_lat = TIMEOUT + 10;
        addr_b = 32'h0000_0600; req_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset sel_o", sel_o, 1);
        chk("pre-reset mem_valid", mem_valid, 1);
        rst = 1'b1; req_b = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset mem_valid", mem_valid, 0);
        chk("post-reset done_b", done_b, 0);
        force_lat = 1;
        rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
        n = 0;
        while (!mem_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 10) fail_now("no grant after reset");
        else chk("tie after reset grants A", sel_o, 0);
        wait_quiet(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one 32-bit memory port between two requesters: A (instruction fetch) and B (load/store). It drives the select of the 2:1 32-bit address/write-data muxes and sequences a valid/ready transaction to memory. Arbitration is round-robin, with a per-transaction timeout. It sits between the fetch/LSU logic and the board memory interface.

Parameters:
DATA_W, 32, width of address, write data and read data
TIMEOUT, 16, max BUSY cycles waiting for mem_ready before abort (must be >= 2)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_a  in  1  requester A transaction request, held until done_a
addr_a  in  DATA_W  A address
wdata_a  in  DATA_W  A write data
we_a  in  1  A write enable
req_b  in  1  requester B request, held until done_b
addr_b  in  DATA_W  B address
wdata_b  in  DATA_W  B write data
we_b  in  1  B write enable
mem_valid  out  1  transaction active toward memory
mem_addr  out  DATA_W  muxed address
mem_wdata  out  DATA_W  muxed write data
mem_we  out  1  muxed write enable, gated by mem_valid
mem_ready  in  1  memory completes current transaction this cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
sel_o  out  1  mux select: 0 = A, 1 = B
done_a  out  1  one-cycle completion pulse to A
done_b  out  1  one-cycle completion pulse to B
rdata_o  out  DATA_W  registered read data, valid with done_a/done_b
err_o  out  1  one-cycle pulse with done_x when a timeout aborts the transaction

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE; sel_o=0; mem_valid=0; mem_we=0.
  - done_a/done_b/err_o=0; rdata_o=0; wait counter=0.
  - last_grant=1, so A wins the first tie.
- States: IDLE, BUSY_A, BUSY_B. sel_o and mem_valid are registered; sel_o is 0 in BUSY_A and 1 in BUSY_B. mem_valid=1 exactly in the BUSY states.
- mem_addr and mem_wdata are combinational mux outputs of the selected requester's inputs. mem_we = mem_valid & selected we.
- IDLE:
  - Only req_a -> BUSY_A. Only req_b -> BUSY_B.
  - Both -> grant the requester that is not last_grant.
  - Latency from req to mem_valid: 1 cycle.
- BUSY_x, mem_ready=1:
  - Capture mem_rdata into rdata_o and pulse done_x on the next cycle (registered).
  - Set last_grant=x and clear the counter.
  - Next state: if the other requester's req is high, go to BUSY_other (back-to-back, no IDLE bubble). Else if x's req is still high, go to IDLE (x must drop req after done). Else IDLE.
- BUSY_x, mem_ready=0:
  - Increment the counter.
  - When the counter reaches TIMEOUT-1 with no ready: abort. Next cycle done_x=1, err_o=1, rdata_o=0, last_grant=x, state IDLE.
- Requester drops req mid-transaction: ignored; the transaction completes normally.
- Writes: rdata_o is captured anyway; requesters ignore it.
- mem_ready in IDLE is ignored.
- mem_ready on the same cycle as the timeout threshold: ready wins, no error.
- rst asserted mid-transaction: abort immediately to reset values. No done pulse is issued.
- done_a and done_b are never high in the same cycle.

Decomposition:
- Shared package:
  - state encoding constants (ST_IDLE=2'd0, ST_BUSY_A=2'd1, ST_BUSY_B=2'd2).
  - SEL_A=1'b0, SEL_B=1'b1.
- Sub-modules: two instances of the existing mux2to1_32bit, one for address and one for write data, both driven by sel_o. The arbiter FSM and counter stay in this module.

Test Plan:
- Reset, then req_a=1, addr_a=0x0000_0040, mem_ready=1 one cycle after mem_valid, mem_rdata=0x1234_5678 -> mem_valid rises 1 cycle after req, sel_o=0, mem_addr=0x40; next cycle done_a=1, rdata_o=0x1234_5678.
- req_a and req_b both high from reset, memory always ready -> grants go A, B, A, B with back-to-back BUSY_A→BUSY_B; done pulses alternate, never coincident.
- req_b=1, we_b=1, wdata_b=0xDEAD_BEEF, addr_b=0x100 -> sel_o=1, mem_we=1, mem_wdata=0xDEADBEEF, mem_addr=0x100; mem_we=0 in IDLE.
- req_a=1, mem_ready held 0 (TIMEOUT=16) -> abort after 16 BUSY cycles; done_a=1 with err_o=1 and rdata_o=0; return to IDLE.
- Edge case, ready at threshold: mem_ready=1 on exactly the 16th BUSY cycle -> done_a=1, err_o=0, data captured.
- Edge case, reset mid-transaction: rst=1 during BUSY_B -> next cycle mem_valid=0, sel_o=0, no done_b pulse; a following req_a and req_b tie grants A.
